// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   state_e : controller state encoding (2'b11 is unused and recovers to IDLE)
//   NIB_W   : width of the shared adder slice in bits
package nibble_serial_adder_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder_ci.sv
// Combinational ripple adder slice with carry-in, built from full-adder cells.
//   full_adder      : a, b, ci -> s, co (1-bit cell)
//   nibble_adder_ci : A[3:0], B[3:0], Cin -> Sum[3:0], Cout
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_adder_ci
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] A,
  input  logic [NIB_W-1:0] B,
  input  logic             Cin,
  output logic [NIB_W-1:0] Sum,
  output logic             Cout
);
  logic [NIB_W:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    full_adder u_fa (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (Sum[i]),
      .co (c[i+1])
    );
  end

  assign Cout = c[NIB_W];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder controller: computes {Co,S} = X + Y + Ci one 4-bit
// nibble per clock (LSB first) through a single shared ripple slice.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   start     : request a new addition (sampled only when not busy)
//   X, Y, Ci  : operands and carry-in, latched on an accepted start
//   busy      : high while nibbles are being computed
//   done      : one-cycle pulse, S and Co valid
//   S, Co     : sum register and final carry-out
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic         Ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         Co
);

  localparam int unsigned NIB   = W / NIB_W;
  localparam int unsigned IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((W % NIB_W) != 0 || W < 8) begin : g_bad_w
    $fatal(1, "nibble_serial_adder_ctrl: W must be a multiple of 4 and >= 8");
  end

  state_e                        state_q;
  logic [NIB-1:0][NIB_W-1:0]     x_q, y_q, s_q;
  logic                          carry_q;
  logic [IDX_W-1:0]              idx_q;
  logic                          busy_q, done_q, co_q;

  logic [NIB_W-1:0]              slice_sum;
  logic                          slice_co;

  nibble_adder_ci u_slice (
    .A    (x_q[idx_q]),
    .B    (y_q[idx_q]),
    .Cin  (carry_q),
    .Sum  (slice_sum),
    .Cout (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // DONE accepts a new start exactly like IDLE so back-to-back
        // operations run without a bubble cycle.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            x_q     <= X;
            y_q     <= Y;
            carry_q <= Ci;
            idx_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          s_q[idx_q] <= slice_sum;
          carry_q    <= slice_co;
          // idx is held on the last step rather than wrapped; it is
          // cleared again on the next accept.
          if (idx_q == LAST_IDX) begin
            co_q    <= slice_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Co   = co_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] X, Y;
  logic         Ci;
  logic         busy, done, Co;
  logic [W-1:0] S;

  int n_cmp    = 0;
  int n_err    = 0;
  int n_acc    = 0;
  int done_cnt = 0;

  nibble_serial_adder_ctrl #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Ci    (Ci),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Co    (Co)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // Starts one operation from an idle/DONE-free point and waits for its
  // result. With noise set, start and the operand inputs are scrambled
  // while the operation runs; the result must depend only on the latched values.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit noise, input string tag);
    logic [W:0] r;
    int cyc;
    r = golden(a, b, c);
    start = 1'b1; X = a; Y = b; Ci = c;
    tick();
    n_acc++;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * NIB) begin
      chk({tag, "_busy"}, busy, 1);
      if (noise) begin
        start = 1'($urandom_range(1));
        X     = W'($urandom);
        Y     = W'($urandom);
        Ci    = 1'($urandom_range(1));
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, cyc, NIB);
    chk({tag, "_S"}, S, r[W-1:0]);
    chk({tag, "_Co"}, Co, r[W]);
    chk({tag, "_busy_at_done"}, busy, 0);
    tick();
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_S_hold"}, S, r[W-1:0]);
    chk({tag, "_Co_hold"}, Co, r[W]);
  endtask

  initial begin
    logic [W:0] r;
    int cyc;
    int dc0;

    rst = 1'b1; start = 1'b0; X = '0; Y = '0; Ci = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", S, 0);
    chk("rst_Co", Co, 0);
    rst = 1'b0;
    tick();

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "ripple");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "allones");
    run_op(16'h0000, 16'h0000, 1'b0, 1'b0, "zeros");

    // Back-to-back: start held high, operands changed during RUN.
    start = 1'b1; X = 16'h00F0; Y = 16'h0010; Ci = 1'b0;
    tick();
    n_acc++;
    X = 16'hAAAA; Y = 16'h5555;
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * NIB) begin tick(); cyc++; end
    chk("b2b_lat1", cyc, NIB);
    chk("b2b_S1", S, 16'h0100);
    chk("b2b_Co1", Co, 0);
    tick();
    n_acc++;
    start = 1'b0;
    chk("b2b_busy2", busy, 1);
    chk("b2b_done2", done, 0);
    chk("b2b_S_cleared", S, 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * NIB) begin tick(); cyc++; end
    chk("b2b_lat2", cyc, NIB);
    chk("b2b_S2", S, 16'hFFFF);
    chk("b2b_Co2", Co, 0);
    tick();

    // Reset during the second RUN cycle aborts the operation.
    start = 1'b1; X = 16'hFFFF; Y = 16'h0001; Ci = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_S", S, 0);
    chk("abort_Co", Co, 0);
    dc0 = done_cnt;
    repeat (2 * NIB) tick();
    chk("abort_no_done", done_cnt - dc0, 0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, "after_abort");

    // Randomised sweep, with noise on inputs during RUN.
    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] a, b;
      logic c;
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom_range(1));
      if (i % 50 == 0) begin a = '1; b = W'(i / 50); end
      run_op(a, b, c, (i % 2) == 1, "rand");
      repeat ($urandom_range(2)) tick();
    end

    tick();
    chk("done_count", done_cnt, n_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencing controller that adds two W-bit operands using one shared 4-bit carry-in ripple slice, processing one nibble per clock from LSB to MSB. A registered carry is threaded between nibbles. A start/busy/done handshake lets wide additions be done in the arithmetic section without replicating adder hardware, trading latency for area.

Parameters:
W, 16, operand and result width in bits. Must be a multiple of 4 and at least 8. Any other value is a fatal configuration error, flagged by an elaboration check.
NIB, W/4, number of nibble steps. Derived only; never overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new addition. Sampled only when not busy.
X  input  W  operand A, captured on an accepted start
Y  input  W  operand B, captured on an accepted start
Ci  input  1  carry-in to nibble 0, captured on an accepted start
busy  output  1  high while nibbles are being computed
done  output  1  one-cycle pulse; S and Co are valid
S  output  W  sum register
Co  output  1  carry-out of the most significant nibble

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, done=0, S=0, Co=0.
  - Internal operand registers, carry register and nibble index all cleared.
  - rst takes priority over everything else.
  - Reset mid-operation aborts the addition; no done pulse is produced for it.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE: start=1 → RUN. At that edge:
  - latch X, Y, Ci into internal registers; carry reg=Ci; idx=0;
  - clear S to 0 and Co to 0.
- RUN, each edge:
  - slice inputs are X_reg[4*idx+3:4*idx], Y_reg[same], carry reg;
  - write the slice sum into S[4*idx+3:4*idx]; slice carry-out goes to the carry reg; idx increments.
  - When idx==NIB-1: also load Co from the slice carry-out and go to DONE.
- DONE (exactly one cycle):
  - start=1 → accept a new operation exactly as from IDLE (back-to-back, no bubble).
  - otherwise → IDLE.
- Latency: start accepted at edge k → done=1 during the cycle after edge k+NIB. For W=16 that is 4 cycles. Throughput is one result per NIB+1 cycles.
- start while busy=1 is ignored; it is not queued.
- X, Y and Ci changes during RUN have no effect (latched operands).
- S and Co hold their last result after DONE until the next accepted start or reset.
- Upper nibbles of S read 0 during RUN until written. Consumers must use S only at or after done.
- Arithmetic: {Co,S} = X + Y + Ci, computed modulo 2^(W+1). No signed interpretation and no overflow flag.
- idx is $clog2(NIB) bits wide and never wraps during RUN; it is cleared on each accept.

Decomposition:
- Shared package/header:
  - state encoding localparams ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10 (2'b11 is illegal and recovers to IDLE);
  - nibble width constant NIB_W=4.
- One natural sub-module: nibble_adder_ci.
  - Combinational 4-bit ripple adder with carry-in: inputs A[3:0], B[3:0], Cin; outputs Sum[3:0], Cout.
  - Built from the team's existing full-adder cell.
  - Instantiated exactly once in the controller.

Test Plan:
- W=16, X=0x1234, Y=0x4321, Ci=0, start pulse → busy=1 for 4 cycles; done pulses once in cycle 5; S=0x5555, Co=0.
- X=0xFFFF, Y=0x0001, Ci=0 → S=0x0000, Co=1. Exercises carry propagating through all four nibbles via the carry reg.
- X=0xFFFF, Y=0xFFFF, Ci=1 → S=0xFFFF, Co=1. Then X=0, Y=0, Ci=0 → S=0x0000, Co=0 (carry reg cleared on accept).
- Start 0x00F0+0x0010, then hold start=1 and change X/Y to 0xAAAA/0x5555 during RUN → first result S=0x0100, Co=0, unaffected by the changes. Start asserted in the DONE cycle launches 0xAAAA+0x5555 immediately → S=0xFFFF, Co=0 done 4 cycles later.
- Assert rst=1 for one edge in the 2nd RUN cycle → busy=0, done=0, S=0, Co=0 next cycle; no done pulse afterwards. A subsequent start works normally.
- Randomised directed sweep of 500 vectors against the golden model {Co,S}=X+Y+Ci → all match; done count equals accepted-start count.
